// File: rtl/load_down_counter.sv
// Loadable down-counter/timer: load a value, start, count to zero, flag terminal count.
// Define LOAD_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from the shadow register.
module load_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count_out <= '0;
            shadow    <= '0;
            tc        <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_out <= count_nxt;
            shadow    <= shadow_nxt;
            tc        <= tc_nxt;
        end
    end

    // Load outranks everything; start and pause are only looked at without a load.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count_out;
        shadow_nxt = shadow;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = load_in;
            shadow_nxt = load_in;
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_out != '0) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt = DONE;
                            tc_nxt    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (count_out > WIDTH'(1)) begin
                            count_nxt = count_out - WIDTH'(1);
                        end else if (count_out == WIDTH'(1)) begin
                            count_nxt = '0;
                            tc_nxt    = 1'b1;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
                            state_nxt = RUN;
`else
                            state_nxt = DONE;
`endif
                        end else begin
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
                            count_nxt = shadow;
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        count_nxt = shadow;
                        if (shadow != '0) begin
                            state_nxt = RUN;
                        end else begin
                            tc_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
